display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_pkg.sv | 24 ++
 rtl/display_scan_ctrl_decodificador.sv | 31 +++
 rtl/display_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit multiplexed display scanner.
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int         NUM_DIG   = 4;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // A digit above position 0 is blanked when enabled and it and every
    // more significant nibble are zero.
    function automatic logic lz_blank(input logic [15:0] val,
                                      input logic [1:0]  dig,
                                      input logic        en);
        logic [15:0] upper;
        upper = val >> {dig, 2'b00};
        return en && (dig != 2'd0) && (upper == 16'd0);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_decodificador.sv
// Hex nibble to active-low seven-segment pattern, bit order abcdefg.
module decodificador (
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    // Pure lookup; one instance is shared by all digits.
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with dead time between digits,
// frame-synchronous value update and optional leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV     = 50000,
    parameter int GAP_CYC = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Valor,
    input  logic        Load,
    input  logic        Enable,
    input  logic        Blank_lz,
    output logic        Ack,
    output logic        Pending,
    output logic [0:6]  DISPLAY,
    output logic [3:0]  Anodo
);

    localparam int CNT_MAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_e           state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      staged_q, staged_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic [3:0]       anodo_q, anodo_d;
    logic [0:6]       display_q, display_d;
    logic             frame_end;
    logic [3:0]       dec_nib;
    logic [0:6]       dec_seg;

    decodificador u_dec (
        .nibble (dec_nib),
        .seg    (dec_seg)
    );

    // Scan sequencer: IDLE -> ON(d) -> GAP(d) -> ON(d+1) ...; Enable low wins.
    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        cnt_d     = cnt_q + CNT_W'(1);
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                digit_d = 2'd0;
                if (Enable) state_d = ST_ON;
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = ST_ON;
                    cnt_d     = '0;
                    digit_d   = digit_q + 2'd1;
                    frame_end = (digit_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                digit_d = 2'd0;
            end
        endcase
        if (!Enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            digit_d   = 2'd0;
            frame_end = 1'b0;
        end
    end

    // Value staging: commit at frame boundaries while scanning, immediately
    // when idle (a value left pending when scanning stopped also commits).
    always_comb begin
        shadow_d  = shadow_q;
        staged_d  = staged_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (Load) begin
                shadow_d  = Valor;
                staged_d  = Valor;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end else if (pending_q) begin
                shadow_d  = staged_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
        end else if (frame_end && (Load || pending_q)) begin
            shadow_d  = Load ? Valor : staged_q;
            staged_d  = Load ? Valor : staged_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else if (Load) begin
            staged_d  = Valor;
            pending_d = 1'b1;
        end
    end

    // Outputs are computed from next-state values so the registered
    // drivers line up with the state the FSM is entering.
    always_comb begin
        dec_nib   = shadow_d[{digit_d, 2'b00} +: 4];
        anodo_d   = ANODE_OFF;
        display_d = SEG_OFF;
        if (state_d == ST_ON && !lz_blank(shadow_d, digit_d, Blank_lz)) begin
            anodo_d   = ~(4'b0001 << digit_d);
            display_d = dec_seg;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            digit_q   <= 2'd0;
            cnt_q     <= '0;
            shadow_q  <= 16'd0;
            staged_q  <= 16'd0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            anodo_q   <= ANODE_OFF;
            display_q <= SEG_OFF;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            staged_q  <= staged_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            anodo_q   <= anodo_d;
            display_q <= display_d;
        end
    end

    assign Ack     = ack_q;
    assign Pending = pending_q;
    assign Anodo   = anodo_q;
    assign DISPLAY = display_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed bench for display_scan_ctrl against a time-based
// reference model (scan position as a cycle offset within the frame).
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = DIV + GAP;
    localparam int FRAME = 4 * SLOT;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Valor = 16'd0;
    logic        Load = 1'b0;
    logic        Enable = 1'b0;
    logic        Blank_lz = 1'b0;
    logic        Ack;
    logic        Pending;
    logic [0:6]  DISPLAY;
    logic [3:0]  Anodo;

    display_scan_ctrl #(.DIV(DIV), .GAP_CYC(GAP)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Valor    (Valor),
        .Load     (Load),
        .Enable   (Enable),
        .Blank_lz (Blank_lz),
        .Ack      (Ack),
        .Pending  (Pending),
        .DISPLAY  (DISPLAY),
        .Anodo    (Anodo)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_act   = 1'b0;
    int          m_t     = 0;
    logic [15:0] m_shadow = 16'd0;
    logic [15:0] m_staged = 16'd0;
    bit          m_pend  = 1'b0;
    bit          m_ack   = 1'b0;
    bit          m_blank = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit l,
                              input logic [15:0] v, input bit b);
        bit boundary;
        m_blank = b;
        if (r) begin
            m_act = 0; m_t = 0; m_shadow = 0; m_staged = 0; m_pend = 0; m_ack = 0;
            return;
        end
        m_ack = 0;
        if (!m_act) begin
            if (l) begin
                m_shadow = v; m_pend = 0; m_ack = 1;
            end else if (m_pend) begin
                m_shadow = m_staged; m_pend = 0; m_ack = 1;
            end
            if (e) begin m_act = 1; m_t = 0; end
        end else if (!e) begin
            m_act = 0; m_t = 0;
            if (l) begin m_staged = v; m_pend = 1; end
        end else begin
            boundary = (m_t == FRAME - 1);
            m_t = boundary ? 0 : m_t + 1;
            if (boundary && (m_pend || l)) begin
                m_shadow = l ? v : m_staged; m_pend = 0; m_ack = 1;
            end else if (l) begin
                m_staged = v; m_pend = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] an;
        logic [6:0] sg;
        int ph, dg;
        logic [15:0] upper;
        an = 4'hF;
        sg = 7'h7F;
        if (m_act) begin
            ph = m_t % SLOT;
            dg = m_t / SLOT;
            upper = m_shadow >> (4 * dg);
            if (ph < DIV && !(dg >= 1 && m_blank && upper == 16'd0)) begin
                an = ~(4'b0001 << dg);
                sg = seg_tab[upper[3:0]];
            end
        end
        chk("ack", 32'(Ack), 32'(m_ack));
        chk("pending", 32'(Pending), 32'(m_pend));
        chk("anodo", 32'(Anodo), 32'(an));
        chk("display", 32'(DISPLAY), 32'(sg));
    endtask

    task automatic step(input bit r, input bit e, input bit l,
                        input logic [15:0] v, input bit b);
        Reset = r; Enable = e; Load = l; Valor = v; Blank_lz = b;
        @(posedge Clock);
        model_edge(r, e, l, v, b);
        @(negedge Clock);
        compare_all();
    endtask

    // Advance with Enable high until the next step lands on the boundary cycle.
    task automatic run_to_boundary(input bit b);
        int guard;
        guard = 0;
        while (m_t != FRAME - 1 && guard < 2 * FRAME) begin
            step(0, 1, 0, 16'h0, b);
            guard++;
        end
        chk("boundary_reached", 32'(m_t), 32'(FRAME - 1));
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 16'h0, 0);
        step(1, 1, 1, 16'hFFFF, 1);
        chk("rst_anodo", 32'(Anodo), 32'h F);
        chk("rst_display", 32'(DISPLAY), 32'h7F);

        // Load while idle with Enable: immediate commit, scan starts at digit 0
        step(0, 1, 1, 16'h1234, 0);
        chk("idle_ack", 32'(Ack), 32'd1);
        chk("d0_anodo", 32'(Anodo), 32'b1110);
        chk("d0_disp4", 32'(DISPLAY), 32'b1001100);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'h0, 0);
            chk("d0_hold", 32'(Anodo), 32'b1110);
        end
        step(0, 1, 0, 16'h0, 0);
        chk("gap_anodo", 32'(Anodo), 32'hF);
        step(0, 1, 0, 16'h0, 0);
        chk("d1_anodo", 32'(Anodo), 32'b1101);
        chk("d1_disp3", 32'(DISPLAY), 32'b0000110);

        // Load during digit 1: pending until frame end
        step(0, 1, 1, 16'hABCD, 0);
        chk("mid_pending", 32'(Pending), 32'd1);
        run_to_boundary(0);
        step(0, 1, 0, 16'h0, 0);
        chk("frame_ack", 32'(Ack), 32'd1);
        chk("frame_dispD", 32'(DISPLAY), 32'b1000010);
        step(0, 1, 0, 16'h0, 0);
        chk("ack_single", 32'(Ack), 32'd0);

        // Staged 0x1111, overwritten by Load on the boundary cycle
        step(0, 1, 1, 16'h1111, 0);
        run_to_boundary(0);
        step(0, 1, 1, 16'h2222, 0);
        chk("bypass_ack", 32'(Ack), 32'd1);
        chk("bypass_pend", 32'(Pending), 32'd0);
        chk("bypass_disp2", 32'(DISPLAY), 32'b0010010);

        // Leading-zero blanking with 0x0050 over two frames
        run_to_boundary(1);
        step(0, 1, 1, 16'h0050, 1);
        for (int i = 0; i < 2 * FRAME; i++) step(0, 1, 0, 16'h0, 1);

        // Enable dropped mid-ON, then re-enabled
        step(0, 1, 0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 1);
        chk("dis_anodo", 32'(Anodo), 32'hF);
        chk("dis_display", 32'(DISPLAY), 32'h7F);
        step(0, 1, 0, 16'h0, 1);
        chk("reen_anodo", 32'(Anodo), 32'b1110);

        // Reset mid-ON with a pending value
        step(0, 1, 1, 16'h9876, 0);
        step(1, 1, 0, 16'h0, 0);
        chk("rst_pend", 32'(Pending), 32'd0);
        chk("rst_ack", 32'(Ack), 32'd0);
        chk("rst2_anodo", 32'(Anodo), 32'hF);
        chk("rst2_display", 32'(DISPLAY), 32'h7F);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, e, l, b;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 59) != 0);
            l = ($urandom_range(0, 14) == 0);
            b = ($urandom_range(0, 3) != 0);
            step(r, e, l, 16'($urandom), b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
